// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR controller. It has one shared multiplier,
// a circular sample buffer, and round/saturate on output.
module fir_mac_sequencer #(
  parameter int NTAPS = 31,
  parameter int DW    = 10,
  parameter int CW    = 16,
  parameter int CFRAC = 15,
  parameter int ACCW  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic [DW-1:0]            sample_in,
  output logic                     sample_ready,
  output logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [CW-1:0]            coef_data,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic                     busy,
  output logic                     overrun,
  input  logic                     overrun_clr
);
  localparam int AW = $clog2(NTAPS);
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, ROUND = 2'd2;
  localparam logic [AW-1:0] KLAST = AW'(NTAPS - 1);
  localparam logic [AW-1:0] NTA = AW'(NTAPS);
  logic [1:0] state;
  logic [AW-1:0] wp, k, rd_idx;
  logic [DW-1:0] smp [NTAPS];
  logic [ACCW-1:0] acc;
  logic [DW+CW-1:0] prod;
  logic [ACCW:0] rsum, r;
  assign sample_ready = state == IDLE;
  assign busy = state == ACCUM || state == ROUND;
  assign coef_addr = k;
  // AW-bit modular arithmetic keeps the wrapped index exact even when NTAPS == 2^AW
  assign rd_idx = wp >= k ? wp - k : wp + NTA - k;
  assign prod = coef_data * smp[rd_idx];
  assign rsum = {1'b0, acc} + ((ACCW + 1)'(1) << (CFRAC - 1));
  assign r = rsum >> CFRAC;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      wp <= '0;
      k <= '0;
      acc <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < NTAPS; i++) smp[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      overrun <= (sample_valid && busy) ? 1'b1 : overrun_clr ? 1'b0 : overrun;
      case (state)
        IDLE: if (sample_valid) begin
          smp[wp] <= sample_in;
          acc <= '0;
          k <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          acc <= acc + ACCW'(prod);
          k <= k == KLAST ? '0 : k + 1'b1;
          if (k == KLAST) begin
            wp <= wp == KLAST ? '0 : wp + 1'b1;
            state <= ROUND;
          end
        end
        ROUND: begin
          out_data <= r > (ACCW + 1)'(2 ** DW - 1) ? '1 : r[DW-1:0];
          out_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
